// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared types and constants for the instruction fetch stage and its
//   consumers.
//   - fetch_state_t : fetch FSM states (IDLE, WAIT)
//   - NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0), the IR reset value
//   - imm_type_t    : immediate-format encodings used by the immediate generator
//   - imm_field()   : extracts the instr[31:7] slice fed to the immediate generator
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ITYPE = 3'd0,
    STYPE = 3'd1,
    BTYPE = 3'd2,
    UTYPE = 3'd3,
    JTYPE = 3'd4
  } imm_type_t;

  function automatic logic [24:0] imm_field(input logic [31:0] ir);
    return ir[31:7];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Instruction-memory read bus between the fetch stage (master) and the
//   instruction memory (slave).
//   mem_addr   master->slave  32  byte address of the read
//   mem_rd_en  master->slave   1  read request, held high until answered
//   mem_rdata  slave->master  32  read data
//   mem_ready  slave->master   1  mem_rdata valid this cycle
//
// Handshake: a read is outstanding while mem_rd_en=1. mem_addr is stable for
// the whole time mem_rd_en is high. The read completes on the first rising
// clock edge where mem_rd_en=1 and mem_ready=1; mem_rdata is sampled only on
// that edge. mem_ready while mem_rd_en=0 carries no meaning and is ignored.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Multi-cycle instruction fetch stage. Owns PC, old-PC and the instruction
//   register (IR). One memory read per fetch_req; the returned word lands in IR
//   and instr_valid pulses for one cycle. A read that is not answered within
//   TIMEOUT_CYC WAIT cycles is abandoned and raises the sticky fetch_err.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   mem          instr_fetch_if.master : instruction memory read bus
//   fetch_req    start a fetch at the current PC (honoured in IDLE only)
//   pc_we        load pc_next into PC (any state)
//   pc_next      next PC from the datapath
//   pc, old_pc   current PC / PC of the instruction held in IR
//   instr        instruction register
//   immed        instr[31:7] for the immediate generator
//   instr_valid  one-cycle pulse: IR updated this cycle
//   busy         high in WAIT
//   fetch_err    sticky error, cleared only by rst
//   state_dbg    current FSM state
//
// Build option
//   FETCH_MISALIGN_TRAP_EN : when defined, a pc_we with pc_next[1:0] != 0 does
//   not write PC and sets fetch_err. When undefined, the low two bits of
//   pc_next are cleared and fetch_err reports timeouts only.
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      mem,
  input  logic               fetch_req,
  input  logic               pc_we,
  input  logic [31:0]        pc_next,
  output logic [31:0]        pc,
  output logic [31:0]        old_pc,
  output logic [31:0]        instr,
  output logic [24:0]        immed,
  output logic               instr_valid,
  output logic               busy,
  output logic               fetch_err,
  output fetch_state_t       state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      old_pc_q, old_pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             start;
  logic             capture;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  // cnt_q holds the number of WAIT cycles already completed, so cnt_inc is
  // the index of the current one; a ready on the limit cycle still captures.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign start       = (state_q == IDLE) && fetch_req;
  assign capture     = (state_q == WAIT) && mem.mem_ready;
  assign timeout_hit = (state_q == WAIT) && !mem.mem_ready && (cnt_inc == CNT_LIMIT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_req) state_d = WAIT;
      WAIT:    if (capture || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem.mem_rd_en = (state_q == WAIT);
    busy          = (state_q == WAIT);
    // The in-flight address stays put even if PC is rewritten during WAIT.
    mem.mem_addr  = (state_q == WAIT) ? fetch_addr_q : pc_q;
  end

  // ---------------- Datapath next values ----------------
  always_comb begin
    pc_d         = pc_q;
    old_pc_d     = old_pc_q;
    instr_d      = instr_q;
    fetch_addr_d = fetch_addr_q;
    cnt_d        = cnt_q;
    valid_d      = 1'b0;
    err_d        = err_q;

    // fetch_addr is taken from the pre-update PC, so a same-cycle pc_we
    // only affects the following fetch.
    if (start) begin
      fetch_addr_d = pc_q;
      cnt_d        = '0;
    end

    if (state_q == WAIT) begin
      cnt_d = cnt_inc;
    end

    if (capture) begin
      instr_d  = mem.mem_rdata;
      old_pc_d = fetch_addr_q;
      valid_d  = 1'b1;
    end

    if (timeout_hit) begin
      err_d = 1'b1;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (pc_we) begin
      if (pc_next[1:0] != 2'b00) err_d = 1'b1;
      else                       pc_d  = pc_next;
    end
`else
    if (pc_we) begin
      pc_d = {pc_next[31:2], 2'b00};
    end
`endif
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  // Low PC bits are discarded in this build.
  logic unused_pc_low;
  assign unused_pc_low = ^pc_next[1:0];
`endif

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      old_pc_q     <= RESET_PC;
      instr_q      <= NOP_INSTR;
      fetch_addr_q <= RESET_PC;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      old_pc_q     <= old_pc_d;
      instr_q      <= instr_d;
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign pc          = pc_q;
  assign old_pc      = old_pc_q;
  assign instr       = instr_q;
  assign immed       = imm_field(instr_q);
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A transaction-level model (one optional
//   outstanding read with an age) is compared against the DUT on every falling
//   edge; literal expectations in the stimulus pin the model to known values.
//   Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          TIMEOUT_CYC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic         fetch_req = 1'b0;
  logic         pc_we     = 1'b0;
  logic [31:0]  pc_next   = '0;
  logic [31:0]  pc, old_pc, instr;
  logic [24:0]  immed;
  logic         instr_valid, busy, fetch_err;
  fetch_state_t state_dbg;

  instr_fetch_if mem_if ();

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem_if),
    .fetch_req  (fetch_req),
    .pc_we      (pc_we),
    .pc_next    (pc_next),
    .pc         (pc),
    .old_pc     (old_pc),
    .instr      (instr),
    .immed      (immed),
    .instr_valid(instr_valid),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One read may be outstanding; it either completes with data or is
  // abandoned once it has been waiting TIMEOUT_CYC cycles.
  logic [31:0] m_pc, m_old_pc, m_instr, m_addr;
  logic        m_valid, m_err, m_inflight;
  int          m_age;
  logic        model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RESET_PC; m_old_pc = RESET_PC; m_instr = 32'h0000_0013;
      m_valid = 1'b0; m_err = 1'b0; m_inflight = 1'b0; m_age = 0; m_addr = RESET_PC;
      model_live = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_inflight) begin
        m_age = m_age + 1;
        if (mem_if.mem_ready) begin
          m_instr = mem_if.mem_rdata; m_old_pc = m_addr; m_valid = 1'b1; m_inflight = 1'b0;
        end else if (m_age >= TIMEOUT_CYC) begin
          m_err = 1'b1; m_inflight = 1'b0;
        end
      end else if (fetch_req) begin
        m_inflight = 1'b1; m_addr = m_pc; m_age = 0;
      end
      if (pc_we) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc_next % 4 != 0) m_err = 1'b1;
        else                  m_pc  = pc_next;
`else
        m_pc = pc_next - (pc_next % 4);
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("pc",          pc,                          m_pc);
      check("old_pc",      old_pc,                      m_old_pc);
      check("instr",       instr,                       m_instr);
      check("immed",       {7'd0, immed},               m_instr / 128);
      check("instr_valid", {31'd0, instr_valid},        {31'd0, m_valid});
      check("busy",        {31'd0, busy},               {31'd0, m_inflight});
      check("mem_rd_en",   {31'd0, mem_if.mem_rd_en},   {31'd0, m_inflight});
      check("mem_addr",    mem_if.mem_addr,             m_inflight ? m_addr : m_pc);
      check("fetch_err",   {31'd0, fetch_err},          {31'd0, m_err});
      check("state",       {31'd0, state_dbg == WAIT},  {31'd0, m_inflight});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_we = 1'b1; pc_next = v;
    tick();
    pc_we = 1'b0;
  endtask

  task automatic respond(input logic [31:0] w);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = w;
    tick();
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
  endtask

  task automatic start_fetch();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] words [4] = '{32'h0000_0093, 32'hfff0_0113, 32'h00c0_00ef, 32'h0020_8463};
  int          lats  [4] = '{1, 3, 7, 16};
  logic [31:0] pre_pc;

  initial begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_pc",        pc,                   32'h0);
    check("rst_instr",     instr,                32'h13);
    check("rst_valid",     {31'd0, instr_valid}, 32'd0);
    check("rst_err",       {31'd0, fetch_err},   32'd0);
    check("rst_rd_en",     {31'd0, mem_if.mem_rd_en}, 32'd0);

    // Minimum-latency fetch
    start_fetch();
    check("t1_rd_en",      {31'd0, mem_if.mem_rd_en}, 32'd1);
    check("t1_addr",       mem_if.mem_addr,      32'h0);
    respond(32'h0050_0093);
    check("t1_valid",      {31'd0, instr_valid}, 32'd1);
    check("t1_instr",      instr,                32'h0050_0093);
    check("t1_immed",      {7'd0, immed},        32'h0000_A001);
    check("t1_old_pc",     old_pc,               32'h0);
    tick();
    check("t1_pulse_end",  {31'd0, instr_valid}, 32'd0);

    // pc_we during WAIT does not move the in-flight fetch
    start_fetch();
    set_pc(32'h40);
    check("t2_pc",         pc,                   32'h40);
    check("t2_inflight",   mem_if.mem_addr,      32'h0);
    respond(32'h00a0_0113);
    check("t2_old_pc",     old_pc,               32'h0);
    check("t2_pc_after",   pc,                   32'h40);
    start_fetch();
    check("t2_next_addr",  mem_if.mem_addr,      32'h40);
    respond(32'h1234_50b7);
    check("t2_old_pc2",    old_pc,               32'h40);

    // Timeout after TIMEOUT_CYC WAIT cycles
    start_fetch();
    repeat (TIMEOUT_CYC - 1) tick();
    check("t3_still_busy", {31'd0, busy},        32'd1);
    check("t3_no_err_yet", {31'd0, fetch_err},   32'd0);
    tick();
    check("t3_idle",       {31'd0, busy},        32'd0);
    check("t3_err",        {31'd0, fetch_err},   32'd1);
    check("t3_ir_kept",    instr,                32'h1234_50b7);
    check("t3_no_valid",   {31'd0, instr_valid}, 32'd0);
    repeat (3) tick();
    check("t3_sticky",     {31'd0, fetch_err},   32'd1);

    // Table of fetches with varied latency, the last answering on the limit cycle
    rst = 1'b1; tick(); rst = 1'b0;
    set_pc(32'h100);
    for (int i = 0; i < 4; i++) begin
      start_fetch();
      repeat (lats[i] - 1) tick();
      respond(words[i]);
      check("t4_valid",    {31'd0, instr_valid}, 32'd1);
      check("t4_instr",    instr,                words[i]);
      check("t4_old_pc",   old_pc,               32'h100 + 32'(4 * i));
      set_pc(32'h100 + 32'(4 * (i + 1)));
    end
    check("t4_no_err",     {31'd0, fetch_err},   32'd0);

    // Misaligned pc_next
    set_pc(32'h40);
    set_pc(32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("t5_pc_held",    pc,                   32'h40);
    check("t5_err",        {31'd0, fetch_err},   32'd1);
`else
    check("t5_pc_clr",     pc,                   32'h40);
    check("t5_no_err",     {31'd0, fetch_err},   32'd0);
`endif
    pre_pc = 32'h40;

    // pc_we and fetch_req together: fetch uses the old PC
    pc_we = 1'b1; pc_next = 32'h80; fetch_req = 1'b1;
    tick();
    pc_we = 1'b0; fetch_req = 1'b0;
    check("t6_addr",       mem_if.mem_addr,      pre_pc);
    check("t6_pc",         pc,                   32'h80);
    respond(32'h0000_0073);
    check("t6_old_pc",     old_pc,               pre_pc);

    // fetch_req in WAIT and together with mem_ready is ignored
    start_fetch();
    fetch_req = 1'b1;
    tick();
    check("t7_ignored",    {31'd0, busy},        32'd1);
    respond(32'h0010_0073);
    fetch_req = 1'b0;
    check("t7_valid",      {31'd0, instr_valid}, 32'd1);
    check("t7_idle",       {31'd0, busy},        32'd0);
    check("t7_old_pc",     old_pc,               32'h80);

    // Reset mid-WAIT; a late mem_ready is ignored
    start_fetch();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t8_idle",       {31'd0, busy},        32'd0);
    check("t8_rd_en",      {31'd0, mem_if.mem_rd_en}, 32'd0);
    check("t8_pc",         pc,                   RESET_PC);
    respond(32'hdead_beef);
    check("t8_no_valid",   {31'd0, instr_valid}, 32'd0);
    check("t8_nop",        instr,                32'h13);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
